// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing plus frame-buffer scanout of a 320x240, 3-bit RGB,
// two-pixels-per-byte image, with every pixel doubled horizontally and vertically.
// Pipeline: stage 0 counters/decode, stage 1 address, stage 2 VRAM read, stage 3 pixel/sync out.
module vga_scanout #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        dot_clk,
    input  logic        reset_n,
    output logic [15:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned HC_W     = $clog2(H_TOTAL);
    localparam int unsigned VC_W     = $clog2(V_TOTAL);
    // One source line of bytes: four displayed dots per byte.
    localparam logic [15:0] LINE_STRIDE = 16'(H_ACTIVE / 4);

    // Stage 0 state
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic [15:0]     line_base;

    // Stage 0 decode
    logic        hc_last_c;
    logic        vc_last_c;
    logic        active_c;
    logic        hs_c;
    logic        vs_c;
    logic        vblank_c;
    logic [15:0] fetch_addr_c;

    // Stage 1 / stage 2 delay lines
    logic act_d1, hs_d1, vs_d1, vb_d1, sel_d1;
    logic act_d2, hs_d2, vs_d2, vb_d2, sel_d2;

    // Stage 3 pixel field select
    logic [2:0] pix_c;

    // Bits 7 and 3 of each byte carry no colour information.
    logic unused_vram_bits_c;
    assign unused_vram_bits_c = vram_data[7] ^ vram_data[3];

    // Region decode and fetch address for the current counter state
    always_comb begin
        hc_last_c    = (hc == HC_W'(H_TOTAL - 1));
        vc_last_c    = (vc == VC_W'(V_TOTAL - 1));
        active_c     = (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
        hs_c         = (hc >= HC_W'(HS_START)) && (hc < HC_W'(HS_END));
        vs_c         = (vc >= VC_W'(VS_START)) && (vc < VC_W'(VS_END));
        vblank_c     = (vc >= VC_W'(V_ACTIVE));
        fetch_addr_c = BASE_ADDR + line_base + 16'(hc >> 2);
    end

    // Dot and line counters; both wrap together at the last dot of the frame
    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc_last_c) begin
            hc <= '0;
            vc <= vc_last_c ? '0 : vc + VC_W'(1);
        end else begin
            hc <= hc + HC_W'(1);
        end
    end

    // Line base advances after every odd active line so each byte row is shown twice
    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            line_base <= '0;
        end else if (hc_last_c && vc_last_c) begin
            line_base <= '0;
        end else if (hc_last_c && vc[0] && (vc < VC_W'(V_ACTIVE))) begin
            line_base <= line_base + LINE_STRIDE;
        end
    end

    // Stage 1: registered VRAM address plus region flags
    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr <= BASE_ADDR;
            act_d1    <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            vb_d1     <= 1'b0;
            sel_d1    <= 1'b0;
        end else begin
            vram_addr <= active_c ? fetch_addr_c : BASE_ADDR;
            act_d1    <= active_c;
            hs_d1     <= hs_c;
            vs_d1     <= vs_c;
            vb_d1     <= vblank_c;
            sel_d1    <= hc[1];
        end
    end

    // Stage 2: flags wait alongside the VRAM read
    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_d2 <= 1'b0;
            hs_d2  <= 1'b0;
            vs_d2  <= 1'b0;
            vb_d2  <= 1'b0;
            sel_d2 <= 1'b0;
        end else begin
            act_d2 <= act_d1;
            hs_d2  <= hs_d1;
            vs_d2  <= vs_d1;
            vb_d2  <= vb_d1;
            sel_d2 <= sel_d1;
        end
    end

    // Left pixel in [6:4], right pixel in [2:0], each ordered {r,g,b}
    always_comb begin
        pix_c = sel_d2 ? vram_data[2:0] : vram_data[6:4];
    end

    // Stage 3: colour and sync outputs, black outside the active area
    always_ff @(posedge dot_clk or negedge reset_n) begin
        if (!reset_n) begin
            r      <= 1'b0;
            g      <= 1'b0;
            b      <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            vblank <= 1'b0;
        end else begin
            {r, g, b} <= act_d2 ? pix_c : 3'b000;
            hsync     <= ~hs_d2;
            vsync     <= ~vs_d2;
            vblank    <= vb_d2;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed scoreboard bench for vga_scanout using a shortened vertical
// frame; two instances share clock/reset, one at base 0000 and one at FF00 to exercise wrap.
module tb_vga_scanout;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 8;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME    = H_TOTAL * V_TOTAL;
    localparam logic [15:0] BASE_A   = 16'h0000;
    localparam logic [15:0] BASE_F   = 16'hFF00;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hsync;
        logic       vsync;
        logic       vblank;
    } vid_t;

    localparam vid_t VID_RST = 6'b000_1_1_0;

    logic        dot_clk = 1'b0;
    logic        reset_n;
    logic        fill_ff;

    logic [15:0] vram_addr_a, vram_addr_f;
    logic [7:0]  vram_data_a, vram_data_f;
    logic        r_a, g_a, b_a, hsync_a, vsync_a, vblank_a;
    logic        r_f, g_f, b_f, hsync_f, vsync_f, vblank_f;
    vid_t        got_a, got_f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_hc, m_vc;
    int hs_fall, vs_fall;
    logic prev_hs, prev_vs;
    vid_t q_a[$];
    vid_t q_f[$];

    always #5 dot_clk = ~dot_clk;

    vga_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BASE_ADDR(BASE_A)
    ) dut_a (
        .dot_clk(dot_clk), .reset_n(reset_n),
        .vram_addr(vram_addr_a), .vram_data(vram_data_a),
        .r(r_a), .g(g_a), .b(b_a),
        .hsync(hsync_a), .vsync(vsync_a), .vblank(vblank_a)
    );

    vga_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BASE_ADDR(BASE_F)
    ) dut_f (
        .dot_clk(dot_clk), .reset_n(reset_n),
        .vram_addr(vram_addr_f), .vram_data(vram_data_f),
        .r(r_f), .g(g_f), .b(b_f),
        .hsync(hsync_f), .vsync(vsync_f), .vblank(vblank_f)
    );

    assign got_a = {r_a, g_a, b_a, hsync_a, vsync_a, vblank_a};
    assign got_f = {r_f, g_f, b_f, hsync_f, vsync_f, vblank_f};

    // VRAM contents: byte 0 reads 8'h75, or all 8'hFF in fill mode
    function automatic logic [7:0] pat(input logic [15:0] a, input logic ff);
        return ff ? 8'hFF : (a[7:0] ^ a[15:8] ^ 8'h75);
    endfunction

    // One-cycle-latency VRAM read ports
    always @(posedge dot_clk) begin
        vram_data_a <= pat(vram_addr_a, fill_ff);
        vram_data_f <= pat(vram_addr_f, fill_ff);
    end

    function automatic logic [15:0] model_addr(input int hc, input int vc, input logic [15:0] base);
        if (hc < int'(H_ACTIVE) && vc < int'(V_ACTIVE))
            return base + 16'((vc / 2) * (H_ACTIVE / 4) + hc / 4);
        return base;
    endfunction

    function automatic vid_t model_vid(input int hc, input int vc, input logic [15:0] base);
        vid_t       v;
        logic [7:0] dat;
        logic       act;
        act      = (hc < int'(H_ACTIVE)) && (vc < int'(V_ACTIVE));
        dat      = pat(model_addr(hc, vc, base), fill_ff);
        v.rgb    = !act ? 3'b000 : (((hc / 2) % 2) == 1) ? dat[2:0] : dat[6:4];
        v.hsync  = !(hc >= int'(H_ACTIVE + H_FP) && hc < int'(H_ACTIVE + H_FP + H_SYNC));
        v.vsync  = !(vc >= int'(V_ACTIVE + V_FP) && vc < int'(V_ACTIVE + V_FP + V_SYNC));
        v.vblank = (vc >= int'(V_ACTIVE));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Assert reset at a falling edge, check async reset values, hold, release and restart the model
    task automatic do_reset(input int n, input logic ff);
        @(negedge dot_clk);
        reset_n = 1'b0;
        fill_ff = ff;
        #1;
        chk("rst_vid_a", 32'(got_a), 32'(VID_RST));
        chk("rst_vid_f", 32'(got_f), 32'(VID_RST));
        chk("rst_addr_a", 32'(vram_addr_a), 32'(BASE_A));
        chk("rst_addr_f", 32'(vram_addr_f), 32'(BASE_F));
        repeat (n) @(posedge dot_clk);
        #1;
        chk("rst_hold_vid_a", 32'(got_a), 32'(VID_RST));
        @(negedge dot_clk);
        reset_n = 1'b1;
        m_hc = 0;
        m_vc = 0;
        hs_fall = -1;
        vs_fall = -1;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        q_a.delete();
        q_f.delete();
        q_a.push_back(VID_RST);
        q_a.push_back(VID_RST);
        q_a.push_back(model_vid(0, 0, BASE_A));
        q_f.push_back(VID_RST);
        q_f.push_back(VID_RST);
        q_f.push_back(model_vid(0, 0, BASE_F));
    endtask

    // Advance one dot: compare DUT outputs with scoreboard, then push the next expectation
    task automatic step();
        logic [15:0] ea_a, ea_f;
        vid_t        ev_a, ev_f;
        ea_a = model_addr(m_hc, m_vc, BASE_A);
        ea_f = model_addr(m_hc, m_vc, BASE_F);
        @(posedge dot_clk);
        #1;
        cyc++;
        ev_a = (q_a.size() > 0) ? q_a.pop_front() : VID_RST;
        ev_f = (q_f.size() > 0) ? q_f.pop_front() : VID_RST;
        chk("vid_a", 32'(got_a), 32'(ev_a));
        chk("vid_f", 32'(got_f), 32'(ev_f));
        chk("addr_a", 32'(vram_addr_a), 32'(ea_a));
        chk("addr_f", 32'(vram_addr_f), 32'(ea_f));
        if (m_vc == 0 && m_hc == 639) chk("addr_l0_d639", 32'(vram_addr_a), 32'h009F);
        if (m_vc == 1 && m_hc == 0)   chk("addr_l1_d0", 32'(vram_addr_a), 32'h0000);
        if (m_vc == 2 && m_hc == 0)   chk("addr_l2_d0", 32'(vram_addr_a), 32'h00A0);
        if (m_vc == 7 && m_hc == 639) chk("addr_l7_d639", 32'(vram_addr_a), 32'h027F);
        if (m_vc == 0 && m_hc == 700) chk("addr_blank", 32'(vram_addr_a), 32'h0000);
        if (m_vc == 4 && m_hc == 0)   chk("addr_f_wrap", 32'(vram_addr_f), 32'h0040);
        if (m_vc == 0 && m_hc == 0)   chk("addr_f_l0", 32'(vram_addr_f), 32'hFF00);
        if (prev_hs && !hsync_a) begin
            if (hs_fall >= 0) chk("hs_period", 32'(cyc - hs_fall), 32'(H_TOTAL));
            hs_fall = cyc;
        end
        if (!prev_hs && hsync_a && hs_fall >= 0) chk("hs_width", 32'(cyc - hs_fall), 32'(H_SYNC));
        if (prev_vs && !vsync_a) begin
            if (vs_fall >= 0) chk("vs_period", 32'(cyc - vs_fall), 32'(FRAME));
            vs_fall = cyc;
        end
        if (!prev_vs && vsync_a && vs_fall >= 0)
            chk("vs_width", 32'(cyc - vs_fall), 32'(V_SYNC * H_TOTAL));
        prev_hs = hsync_a;
        prev_vs = vsync_a;
        if (m_hc == int'(H_TOTAL) - 1) begin
            m_hc = 0;
            m_vc = (m_vc == int'(V_TOTAL) - 1) ? 0 : m_vc + 1;
        end else begin
            m_hc++;
        end
        q_a.push_back(model_vid(m_hc, m_vc, BASE_A));
        q_f.push_back(model_vid(m_hc, m_vc, BASE_F));
    endtask

    initial begin
        int   lit;
        int   k;
        int   guard;
        logic seen;
        logic pv;

        reset_n = 1'b1;
        fill_ff = 1'b0;

        // Reset and first pixel: byte 0 = 75 shows 111 on edges 3-4, 101 on edges 5-6
        do_reset(4, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e <= 2)      chk("first_black", 32'({r_a, g_a, b_a}), 32'h0);
            else if (e <= 4) chk("first_left", 32'({r_a, g_a, b_a}), 32'h7);
            else             chk("first_right", 32'({r_a, g_a, b_a}), 32'h5);
        end

        // Two full frames of timing, addressing and pixel data
        for (int i = 6; i < int'(2 * FRAME); i++) step();

        // Blanking with all-ones VRAM
        do_reset(3, 1'b1);
        lit = 0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            if ({r_a, g_a, b_a} == 3'b111) lit++;
        end
        chk("blank_lit_count", 32'(lit), 32'(H_ACTIVE * V_ACTIVE));

        // Mid-frame reset at line 4, dot 300
        do_reset(2, 1'b0);
        guard = 0;
        while (!(m_vc == 4 && m_hc == 300) && guard < int'(FRAME)) begin
            step();
            guard++;
        end
        chk("reach_mid_frame", 32'(m_vc * 1000 + m_hc), 32'(4300));
        do_reset(5, 1'b0);
        step();
        chk("addr_edge1", 32'(vram_addr_a), 32'(BASE_A));
        k    = 1;
        seen = 1'b0;
        while (!seen && k < int'(FRAME)) begin
            pv = vsync_a;
            step();
            k++;
            if (pv && !vsync_a) seen = 1'b1;
        end
        chk("vs_after_reset", 32'(k), 32'((V_ACTIVE + V_FP) * H_TOTAL + 3));
        for (int i = 0; i < 2000; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
